// File: rtl/move_cmd_ctrl_if.sv
// Handshake bundle between the button front end, move_cmd_ctrl and the board-update FSM.
// The slave modport is the command controller; the master modport is its surroundings.
interface move_cmd_ctrl_if;
  logic [3:0] btn;        // bit0 up, bit1 down, bit2 left, bit3 right
  logic       game_busy;
  logic       cmd_ack;
  logic       cmd_valid;
  logic [1:0] cmd_dir;    // 00 up, 01 down, 10 left, 11 right
  logic [1:0] state_dbg;  // 00 IDLE, 01 ISSUE, 10 WAIT_REL

  modport master (
    output btn, game_busy, cmd_ack,
    input  cmd_valid, cmd_dir, state_dbg
  );

  modport slave (
    input  btn, game_busy, cmd_ack,
    output cmd_valid, cmd_dir, state_dbg
  );
endinterface

// File: rtl/move_cmd_ctrl.sv
// Turns debounced direction buttons into single acknowledged move commands for the 2048 board.
// Optional auto-repeat while a direction stays held: define AUTO_REPEAT_EN.
module move_cmd_ctrl #(
  parameter int unsigned CNT_W         = 20,
  parameter int unsigned MIN_PRESS     = 1000,
  parameter int unsigned REPEAT_DELAY  = 500000,
  parameter int unsigned REPEAT_PERIOD = 200000
) (
  input  logic           clk,
  input  logic           clr,
  move_cmd_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ISSUE    = 2'b01,
    WAIT_REL = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] PRESS_MAX = CNT_W'(MIN_PRESS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  logic             cmd_valid_q;
  logic [1:0]       cmd_dir_q;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] rel_cnt;
  logic             prev_v;
  logic [1:0]       prev_dir;

  logic [1:0]       cand;
  logic             cand_v;
  logic             same_cand;
  logic [CNT_W-1:0] hold_nxt;
  logic             press_ok;
  logic             rel_done;

  // Fixed priority: up > down > left > right.
  always_comb begin
    cand = 2'd0;
    if (bus.btn[0])      cand = 2'd0;
    else if (bus.btn[1]) cand = 2'd1;
    else if (bus.btn[2]) cand = 2'd2;
    else if (bus.btn[3]) cand = 2'd3;
  end

  assign cand_v    = |bus.btn;
  assign same_cand = cand_v && prev_v && (cand == prev_dir);

  // The first sample of a new candidate counts as 0, so the MIN_PRESS-th sample lands on PRESS_MAX.
  assign hold_nxt  = !same_cand             ? '0        :
                     (hold_cnt >= PRESS_MAX) ? PRESS_MAX : hold_cnt + CNT_ONE;
  assign press_ok  = cand_v && (hold_nxt == PRESS_MAX);
  assign rel_done  = !cand_v && (rel_cnt == PRESS_MAX);

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_MAX  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_MAX = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rep_cnt;
  logic             rep_block;
  logic             rep_again;
  logic             rep_match;
  logic [CNT_W-1:0] rep_lim;

  assign rep_match = (bus.btn == (4'b0001 << cmd_dir_q));
  assign rep_lim   = rep_again ? PERIOD_MAX : DELAY_MAX;
`endif

  // NOTE: every register here, state and counters alike, is written with <= and cleared by the async reset.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state       <= IDLE;
      cmd_valid_q <= 1'b0;
      cmd_dir_q   <= 2'd0;
      hold_cnt    <= '0;
      rel_cnt     <= '0;
      prev_v      <= 1'b0;
      prev_dir    <= 2'd0;
`ifdef AUTO_REPEAT_EN
      rep_cnt     <= '0;
      rep_block   <= 1'b0;
      rep_again   <= 1'b0;
`endif
    end else begin
      prev_v   <= cand_v;
      prev_dir <= cand;

      case (state)
        IDLE: begin
          hold_cnt <= hold_nxt;
          if (press_ok && !bus.game_busy) begin
            cmd_dir_q   <= cand;
            cmd_valid_q <= 1'b1;
            hold_cnt    <= '0;
            state       <= ISSUE;
`ifdef AUTO_REPEAT_EN
            rep_again   <= 1'b0;
`endif
          end
        end

        ISSUE: begin
          // Button activity is ignored here; only the acknowledge moves us on.
          if (cmd_valid_q && bus.cmd_ack) begin
            cmd_valid_q <= 1'b0;
            hold_cnt    <= '0;
            rel_cnt     <= '0;
            state       <= WAIT_REL;
`ifdef AUTO_REPEAT_EN
            rep_cnt     <= '0;
            rep_block   <= 1'b0;
`endif
          end
        end

        WAIT_REL: begin
          if (rel_done) begin
            rel_cnt <= '0;
            state   <= IDLE;
          end else if (!cand_v) begin
            rel_cnt <= rel_cnt + CNT_ONE;
          end else begin
            rel_cnt <= '0;
          end
`ifdef AUTO_REPEAT_EN
          // Only the issued direction held alone keeps the repeat timer running.
          if (!rep_match) begin
            rep_cnt   <= '0;
            rep_block <= 1'b1;
          end else if (!rep_block) begin
            if (rep_cnt >= rep_lim) begin
              if (!bus.game_busy) begin
                cmd_valid_q <= 1'b1;
                rep_again   <= 1'b1;
                rep_cnt     <= '0;
                state       <= ISSUE;
              end
            end else begin
              rep_cnt <= rep_cnt + CNT_ONE;
            end
          end
`endif
        end

        default: begin
          cmd_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_dir   = cmd_dir_q;
  assign bus.state_dbg = state;

endmodule

// File: doc/move_cmd_ctrl.md
Name: move_cmd_ctrl

Overview:
- Sequences the four debounced direction buttons of the 2048 board into single, acknowledged move commands for the game logic.
- Qualifies each press by a minimum hold time and resolves simultaneous presses by fixed priority.
- Holds the command until the game logic acknowledges it, then locks out further commands until all buttons are released.
- Sits between the per-button debounce stages and the board-update FSM.

Parameters:
- CNT_W, 20, width of the hold/release counters.
- MIN_PRESS, 1000, cycles a button must be continuously high (press) or all buttons low (release) to qualify; legal range 1..2^CNT_W-1.
- REPEAT_DELAY, 500000, cycles from ack to the first auto-repeat (AUTO_REPEAT_EN only).
- REPEAT_PERIOD, 200000, cycles between subsequent auto-repeats (AUTO_REPEAT_EN only).

Ports:
- clk  in  1  system clock, all state on rising edge
- clr  in  1  asynchronous active-high reset
- btn  in  4  debounced buttons; bit0 up, bit1 down, bit2 left, bit3 right
- game_busy  in  1  board logic busy; no new command issued while high
- cmd_ack  in  1  board logic accepts the current command
- cmd_valid  out  1  command pending
- cmd_dir  out  2  00 up, 01 down, 10 left, 11 right
- state_dbg  out  2  current state: 00 IDLE, 01 ISSUE, 10 WAIT_REL

Behaviour:
- Reset (clr high, asynchronous): state IDLE, cmd_valid 0, cmd_dir 00, all counters 0, state_dbg 00.
- clr asserted in any state drops cmd_valid immediately.
- All outputs are registered.
- cand = lowest-index set bit of btn (priority up > down > left > right); cand_v = |btn.

IDLE:
- hold_cnt clears when cand_v = 0 or cand differs from the previous cycle; otherwise it increments, saturating at MIN_PRESS-1.
- When hold_cnt = MIN_PRESS-1, cand is unchanged and game_busy = 0: load cmd_dir = cand, set cmd_valid = 1, go to ISSUE.
- Net latency: cmd_valid is high after the MIN_PRESS-th rising edge that samples the button high.
- If game_busy = 1 at qualification, stay in IDLE with the counter saturated. Issue on the first edge where busy = 0 and the button is still held.
- A press shorter than MIN_PRESS cycles produces nothing.

ISSUE:
- cmd_valid and cmd_dir are held constant until cmd_ack is sampled high.
- On that edge: cmd_valid goes to 0, go to WAIT_REL, clear counters.
- Releasing or changing btn during ISSUE does not withdraw or alter the command.
- cmd_ack while cmd_valid = 0 is ignored in every state.

WAIT_REL:
- rel_cnt increments while btn = 0 and clears on any set bit.
- When rel_cnt reaches MIN_PRESS-1 with btn = 0: go to IDLE.
- Pressing other buttons during WAIT_REL never issues a command; a full release is required first.

Simultaneous events:
- cmd_ack and a btn change on the same edge: the ack is processed, and btn is evaluated from WAIT_REL rules on the next cycle.

Counters:
- Unsigned, CNT_W bits, saturating; they never wrap.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - In WAIT_REL, rep_cnt counts cycles since ack while btn is one-hot and equal to the issued direction.
  - At REPEAT_DELAY-1 (first repeat) or REPEAT_PERIOD-1 (subsequent repeats) with game_busy = 0: re-enter ISSUE with the same cmd_dir and cmd_valid = 1; rep_cnt clears on ack.
  - Any other btn pattern clears rep_cnt and suppresses repeat until full release.
- Not defined:
  - rep_cnt and its logic are absent.
  - WAIT_REL only waits for release.
  - REPEAT_* parameters are unused.

Test Plan:
1. Reset, MIN_PRESS=4: pulse clr high mid-cycle with btn=0001 -> cmd_valid=0, cmd_dir=00, state_dbg=00 immediately; no command until 4 edges after clr falls.
2. btn=0100 held 20 cycles, cmd_ack pulsed 2 cycles after cmd_valid rises -> cmd_valid high after 4th edge, cmd_dir=10, low the cycle after ack. No further command while held (macro off).
3. Glitch: btn=0001 for 3 cycles then 0000 -> cmd_valid stays 0. Then btn=0001 held 4+ cycles -> cmd_valid=1, cmd_dir=00.
4. btn=1010 simultaneously -> cmd_dir=01. After ack, btn=1000 -> no command. btn=0000 for 4 cycles then 1000 for 4 cycles -> cmd_dir=11.
5. game_busy=1 while btn=0010 qualifies, busy drops 10 cycles later -> cmd_valid rises the edge after busy low. If btn is released before busy drops -> no command.
6. AUTO_REPEAT_EN, REPEAT_DELAY=8, REPEAT_PERIOD=3, immediate acks, btn=0001 held -> first command at edge 4, then repeats with cmd_dir=00 at 8 cycles and then every 3 cycles after each ack. Changing btn to 0011 stops repeats.
